// File: rtl/updown_seek_controller_if.sv
// Seek-request channel: valid/ready handshake carrying target, path mode and prescale.
interface updown_seek_controller_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned DIV_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [N-1:0]     req_target;
  logic             req_shortest;
  logic [DIV_W-1:0] req_prescale;

  modport master (
    output req_valid,
    output req_target,
    output req_shortest,
    output req_prescale,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_target,
    input  req_shortest,
    input  req_prescale,
    output req_ready
  );
endinterface

// File: rtl/updown_seek_controller.sv
// Drives enable/direction of an external up/down counter until its value reaches a
// requested target; one step per prescale period, direction fixed at accept time.
module updown_seek_controller #(
  parameter int unsigned N     = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  updown_seek_controller_if.slave    req,
  input  logic                       abort,
  input  logic [N-1:0]               cnt_q,
  output logic                       cnt_en,
  output logic                       cnt_up,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [N-1:0]               step_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};

  state_e           state_q, state_d;
  logic [N-1:0]     target_q, target_d;
  logic [DIV_W-1:0] p_q, p_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             aborted_q, aborted_d;
  logic [N-1:0]     step_cnt_q, step_cnt_d;

  logic [N-1:0]     d_up;
  logic             dir_new;
  logic             accept;
  logic             at_target;
  logic             div_wrap;
  logic             step_en;

  // Shortest path: a modular up-distance of exactly half the range counts as up.
  assign d_up      = req.req_target - cnt_q;
  assign dir_new   = req.req_shortest ? (d_up <= HALF) : (req.req_target > cnt_q);
  assign accept    = req.req_valid && (state_q == S_IDLE);
  assign at_target = (cnt_q == target_q);
  assign div_wrap  = (div_q == p_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      p_q        <= '0;
      dir_q      <= 1'b0;
      div_q      <= '0;
      aborted_q  <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      p_q        <= p_d;
      dir_q      <= dir_d;
      div_q      <= div_d;
      aborted_q  <= aborted_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    p_d        = p_q;
    dir_d      = dir_q;
    div_d      = div_q;
    aborted_d  = aborted_q;
    step_cnt_d = step_cnt_q;
    step_en    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_SEEK;
          target_d   = req.req_target;
          p_d        = req.req_prescale;
          dir_d      = dir_new;
          div_d      = '0;
          aborted_d  = 1'b0;
          step_cnt_d = '0;
        end
      end

      S_SEEK: begin
        // Abort outranks both a pending step and target equality in the same cycle.
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (at_target) begin
          state_d   = S_DONE;
          aborted_d = 1'b0;
        end else begin
          div_d = div_wrap ? '0 : div_q + 1'b1;
          if (div_wrap) begin
            step_en    = 1'b1;
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req.req_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign cnt_en        = step_en;
  assign cnt_up        = dir_q;
  assign aborted       = aborted_q;
  assign step_count    = step_cnt_q;

endmodule

// File: tb/tb_updown_seek_controller.sv
// Directed bench: a behavioural up/down counter closes the loop; each accepted seek
// pushes its expected step schedule and completion to a scoreboard checked by a monitor.
module tb_updown_seek_controller;
  localparam int unsigned N     = 8;
  localparam int unsigned DIV_W = 4;

  typedef struct {
    int k;
    int p;
    int d;
    int up;
    int ab;
    int tgt;
    int done_cyc;
  } item_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             abort = 1'b0;
  logic [N-1:0]     cnt = '0;
  logic             load = 1'b0;
  logic [N-1:0]     load_val = '0;
  logic             cnt_en, cnt_up, busy, done, aborted;
  logic [N-1:0]     step_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stepi = 0;
  item_t sb[$];
  item_t mon_it;

  updown_seek_controller_if #(.N(N), .DIV_W(DIV_W)) req_if ();

  updown_seek_controller #(.N(N), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req_if),
    .abort      (abort),
    .cnt_q      (cnt),
    .cnt_en     (cnt_en),
    .cnt_up     (cnt_up),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External up/down counter, with a preload port for setting up each case.
  always @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (cnt_en) cnt <= cnt_up ? cnt + 1'b1 : cnt - 1'b1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      stepi = 0;
    end else begin
      if (cnt_en) begin
        if (sb.size() == 0) begin
          chk("step_without_seek", sb.size(), 1);
        end else begin
          mon_it = sb[0];
          chk("step_index", int'(stepi < mon_it.d), 1);
          chk("step_cycle", cyc, mon_it.k + 1 + mon_it.p + stepi * (mon_it.p + 1));
          chk("step_dir", int'(cnt_up), mon_it.up);
          stepi++;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_without_seek", sb.size(), 1);
        end else begin
          mon_it = sb.pop_front();
          chk("done_cycle", cyc, mon_it.done_cyc);
          chk("step_count", int'(step_count), mon_it.d);
          chk("aborted", int'(aborted), mon_it.ab);
          chk("steps_seen", stepi, mon_it.d);
          if (mon_it.ab == 0) chk("cnt_at_target", int'(cnt), mon_it.tgt);
          stepi = 0;
        end
      end
    end
  end

  // Preload counter, present one request, push the expected outcome.
  // ab_step >= 0 means the caller aborts in the cycle of that step index.
  task automatic seek(input int c0, input int tgt, input int sh, input int p,
                      input int up, input int d, input int ab_step, output int k);
    item_t it;
    @(negedge clk);
    load = 1'b1;
    load_val = N'(c0);
    @(negedge clk);
    load = 1'b0;
    req_if.req_valid    = 1'b1;
    req_if.req_target   = N'(tgt);
    req_if.req_shortest = (sh != 0);
    req_if.req_prescale = DIV_W'(p);
    chk("ready_at_req", int'(req_if.req_ready), 1);
    k = cyc;
    it.k = k;
    it.p = p;
    it.up = up;
    it.tgt = tgt;
    if (ab_step >= 0) begin
      it.d = ab_step;
      it.ab = 1;
      it.done_cyc = k + 1 + p + ab_step * (p + 1) + 1;
    end else begin
      it.d = d;
      it.ab = 0;
      it.done_cyc = k + d * (p + 1) + 2;
    end
    sb.push_back(it);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    chk("ready_low_in_seek", int'(req_if.req_ready), 0);
    chk("dir_latched", int'(cnt_up), up);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < limit);
    chk("seek_finished_in_budget", int'(n < limit), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    req_if.req_valid    = 1'b0;
    req_if.req_target   = '0;
    req_if.req_shortest = 1'b0;
    req_if.req_prescale = '0;

    @(negedge clk);
    chk("rst_ready", int'(req_if.req_ready), 1);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_cnt_up", int'(cnt_up), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_step_count", int'(step_count), 0);
    reset_n = 1'b1;

    // Linear up, no prescale.
    seek(0, 3, 0, 0, 1, 3, -1, k);
    wait_idle(50);

    // Linear down with prescale; a second request during the seek is ignored.
    seek(10, 8, 0, 2, 0, 2, -1, k);
    req_if.req_valid  = 1'b1;
    req_if.req_target = 8'd200;
    repeat (2) @(negedge clk);
    req_if.req_valid  = 1'b0;
    wait_idle(50);

    // Shortest path wraps through 255 -> 0; linear path goes the long way down.
    seek(250, 4, 1, 0, 1, 10, -1, k);
    wait_idle(50);
    seek(250, 4, 0, 0, 0, 246, -1, k);
    wait_idle(400);

    // Exact half-range tie goes up.
    seek(0, 128, 1, 0, 1, 128, -1, k);
    wait_idle(300);

    // Zero distance, both path modes.
    seek(77, 77, 1, 3, 1, 0, -1, k);
    wait_idle(20);
    seek(77, 77, 0, 1, 0, 0, -1, k);
    wait_idle(20);

    // Shortest path downward with prescale.
    seek(5, 250, 1, 1, 0, 11, -1, k);
    wait_idle(100);

    // Abort in IDLE is ignored.
    @(negedge clk);
    abort = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    abort = 1'b0;

    // Abort coinciding with the third step (p=1: steps at k+2, k+4, k+6).
    seek(20, 30, 0, 1, 1, 10, 2, k);
    while (cyc < k + 5) @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_idle(20);
    repeat (3) @(negedge clk);
    chk("step_count_frozen", int'(step_count), 2);
    chk("aborted_held", int'(aborted), 1);
    chk("cnt_after_abort", int'(cnt), 22);
    seek(22, 25, 0, 0, 1, 3, -1, k);
    wait_idle(20);

    // Asynchronous reset in the middle of a seek.
    seek(0, 100, 0, 0, 1, 100, -1, k);
    repeat (10) @(negedge clk);
    chk("cnt_en_before_reset", int'(cnt_en), 1);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_ready", int'(req_if.req_ready), 1);
    chk("mid_rst_cnt_en", int'(cnt_en), 0);
    chk("mid_rst_cnt_up", int'(cnt_up), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_aborted", int'(aborted), 0);
    chk("mid_rst_step_count", int'(step_count), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seek(40, 35, 0, 0, 0, 5, -1, k);
    wait_idle(30);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
